// File: rtl/lp_sched_pkg.sv
// Shared constants and filter arithmetic for the multi-channel IIR scheduler.
// The update function matches the single-channel low-pass filter exactly.
package lp_sched_pkg;

    localparam int LP_R    = 14;
    localparam int LP_N    = 4;
    localparam int LP_S    = 64;
    localparam int LP_SH   = 14;
    localparam int TAU_W   = 6;
    localparam int BYP_LSB = 4;

    typedef logic signed [LP_S-1:0] acc_t;

    // One filter step: n = x - ((a >>> SH) >>> t) + a, saturated to S bits.
    function automatic acc_t lp_update(
        input acc_t       x,
        input acc_t       a,
        input logic [3:0] t
    );
        logic signed [LP_S-LP_SH-1:0] d;
        logic signed [LP_S:0]         n;
        d = (LP_S-LP_SH)'((a >>> LP_SH) >>> t);
        n = {x[LP_S-1], x}
          - {{(LP_SH+1){d[LP_S-LP_SH-1]}}, d}
          + {a[LP_S-1], a};
        case (n[LP_S:LP_S-1])
            2'b01:   lp_update = {1'b0, {(LP_S-1){1'b1}}};
            2'b10:   lp_update = {1'b1, {(LP_S-1){1'b0}}};
            default: lp_update = n[LP_S-1:0];
        endcase
    endfunction

    // Output scaling of an accumulator value.
    function automatic acc_t lp_scale(
        input acc_t       v,
        input logic [3:0] t
    );
        lp_scale = (v >>> LP_SH) >>> t;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// The pointer moves to the slot after the granted one on every grant.
module rr_arbiter
    import lp_sched_pkg::*;
#(
    parameter  int N  = LP_N,
    localparam int PW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx,
    output logic          gvalid
);

    logic [PW-1:0] ptr;

    // Grant the first requester at or after ptr, wrapping around
    always_comb begin
        int            j;
        logic [PW-1:0] idx;
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        j      = 0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            j   = (int'(ptr) + i) % N;
            idx = PW'(j);
            if (!gvalid && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                gvalid     = 1'b1;
            end
        end
    end

    // Advance the pointer past the channel just granted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (gvalid) begin
            if (int'(gidx) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= gidx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lp_filter_sched.sv
// Shared first-order low-pass update for N lock-in channels.
// Round-robin accept, per-channel accumulators, 2-stage update pipeline.
module lp_filter_sched
    import lp_sched_pkg::*;
#(
    parameter int R = LP_R,
    parameter int N = LP_N
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N*TAU_W-1:0] tau,
    input  logic [N*R-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N-1:0]     clr,
    output logic [N*R-1:0]   out_data,
    output logic [N-1:0]     out_valid,
    output logic             busy
);

    localparam int S  = LP_S;
    localparam int GW = $clog2(N);

    logic [GW-1:0]         g;
    logic                  gv;
    acc_t                  acc [N];
    acc_t                  rd_a;
    acc_t                  x_ext;
    acc_t                  s2_sum;
    logic                  s1_v;
    logic [GW-1:0]         s1_g;
    logic signed [R-1:0]   s1_x;
    logic [TAU_W-1:0]      s1_tau;
    acc_t                  s1_a;
    logic                  bypass;
    logic signed [R-1:0]   s2_out;

    rr_arbiter #(.N(N)) u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req    (in_valid),
        .grant  (in_ready),
        .gidx   (g),
        .gvalid (gv)
    );

    // Accumulator read: a clear forces 0, else forward the in-flight result
    always_comb begin
        rd_a = acc[g];
        if (clr[g]) begin
            rd_a = '0;
        end else if (s1_v && (s1_g == g)) begin
            rd_a = s2_sum;
        end
    end

    // Stage-2 arithmetic on the registered stage-1 bundle
    always_comb begin
        x_ext  = {{(S-R){s1_x[R-1]}}, s1_x};
        s2_sum = lp_update(x_ext, s1_a, s1_tau[3:0]);
        bypass = |s1_tau[TAU_W-1:BYP_LSB];
        s2_out = bypass ? s1_x : R'(lp_scale(s2_sum, s1_tau[3:0]));
    end

    // Stage 1: capture the granted channel, its sample, tau and accumulator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v   <= 1'b0;
            s1_g   <= '0;
            s1_x   <= '0;
            s1_tau <= '0;
            s1_a   <= '0;
        end else begin
            s1_v <= gv;
            if (gv) begin
                s1_g   <= g;
                s1_x   <= in_data[g*R +: R];
                s1_tau <= tau[g*TAU_W +: TAU_W];
                s1_a   <= rd_a;
            end
        end
    end

    // Accumulator write-back; a clear overrides the stage-2 write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) begin
                acc[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (clr[k]) begin
                    acc[k] <= '0;
                end else if (s1_v && (s1_g == GW'(k))) begin
                    acc[k] <= s2_sum;
                end
            end
        end
    end

    // Registered per-channel outputs with a one-cycle valid pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            out_valid <= '0;
            if (s1_v) begin
                out_valid[s1_g]        <= 1'b1;
                out_data[s1_g*R +: R]  <= s2_out;
            end
        end
    end

    assign busy = s1_v | (|out_valid);

endmodule

// File: tb/tb_lp_filter_sched.sv
// Scoreboard bench for lp_filter_sched: predictor pushes expected outputs,
// a separate monitor pops and compares them when out_valid pulses.
module tb_lp_filter_sched;

    logic        clk;
    logic        rstn;
    logic [23:0] tau;
    logic [55:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  clr;
    logic [55:0] out_data;
    logic [3:0]  out_valid;
    logic        busy;

    lp_filter_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .tau       (tau),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clr       (clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    typedef struct {
        int                 ch;
        logic signed [13:0] data;
        int                 due;
    } exp_t;

    localparam logic signed [64:0] HI = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] LO = -HI - 65'sd1;

    exp_t   q[$];
    longint m_acc [4];
    int     m_ptr;
    int     gcnt [4];
    int     total;
    int     bad;
    int     cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic int m_grant(logic [3:0] v, int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // Predictor: reference arbiter and filter; pushes expected outputs
    always @(negedge clk) begin
        int                 g;
        longint             a;
        longint             d;
        longint             s;
        longint             sc;
        logic signed [64:0] n;
        logic signed [13:0] x;
        logic [5:0]         t;
        logic [3:0]         er;
        exp_t               e;
        if (!rstn) begin
            m_ptr = 0;
            for (int k = 0; k < 4; k++) m_acc[k] = 0;
            q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (clr[k]) m_acc[k] = 0;
                if (in_valid[k] && in_ready[k]) gcnt[k]++;
            end
            g  = m_grant(in_valid, m_ptr);
            er = (g >= 0) ? 4'(1 << g) : 4'b0;
            check("in_ready", longint'(in_ready), longint'(er));
            if (g >= 0) begin
                x = in_data[g*14 +: 14];
                t = tau[g*6 +: 6];
                a = m_acc[g];
                d = (a >>> 14) >>> t[3:0];
                n = x;
                n = n - d + a;
                if (n > HI) s = HI[63:0];
                else if (n < LO) s = LO[63:0];
                else s = n[63:0];
                e.ch  = g;
                e.due = cyc + 2;
                if (t[5:4] != 2'b00) begin
                    e.data = x;
                end else begin
                    sc     = (s >>> 14) >>> t[3:0];
                    e.data = sc[13:0];
                end
                q.push_back(e);
                m_acc[g] = s;
                m_ptr    = (g + 1) % 4;
            end
        end
    end

    // Monitor: compare each out_valid pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k]) begin
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", k, -1);
                    end else begin
                        e = q.pop_front();
                        check("out_ch", k, e.ch);
                        check("out_cycle", cyc, e.due);
                        check("out_data",
                              longint'($signed(out_data[k*14 +: 14])),
                              longint'(e.data));
                    end
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_x(int k, int x);
        in_data[k*14 +: 14] = 14'(x);
    endtask

    task automatic set_tau(int k, int t);
        tau[k*6 +: 6] = 6'(t);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        m_ptr    = 0;
        rstn     = 1'b0;
        tau      = '0;
        in_data  = '0;
        in_valid = '0;
        clr      = '0;
        for (int k = 0; k < 4; k++) gcnt[k] = 0;

        tick(3);
        check("rst_out_data", longint'(out_data != 0), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_in_ready", longint'(in_ready), 0);
        rstn = 1'b1;
        tick(2);

        // channel 0 constant 1000, tau 0, back-to-back
        set_x(0, 1000);
        in_valid = 4'b0001;
        tick(300);
        in_valid = '0;
        tick(3);

        // channel 1 alone every cycle: forwarding path
        set_x(1, 4000);
        in_valid = 4'b0010;
        tick(2000);
        in_valid = '0;
        tick(3);

        // fairness with all four valid, then channel 2 dropped
        set_x(0, 100);
        set_x(1, -200);
        set_x(2, 8191);
        set_x(3, -8192);
        set_tau(1, 2);
        set_tau(3, 5);
        for (int k = 0; k < 4; k++) gcnt[k] = 0;
        in_valid = 4'b1111;
        tick(100);
        for (int k = 0; k < 4; k++) check("fair_count", gcnt[k], 25);
        in_valid = 4'b1011;
        tick(12);
        in_valid = '0;
        tick(3);

        // bypass on channel 3, then back to filtering
        set_tau(3, 16);
        in_valid = 4'b1000;
        set_x(3, -8192);
        tick();
        set_x(3, 0);
        tick();
        set_x(3, 8191);
        tick();
        in_valid = '0;
        tick(3);
        set_tau(3, 0);
        in_valid = 4'b1000;
        tick(5);
        in_valid = '0;
        tick(3);

        // clear while channel 2 is in stage 2
        set_tau(2, 0);
        set_x(2, 8191);
        in_valid = 4'b0100;
        tick(2000);
        set_x(2, 3000);
        tick();
        in_valid = '0;
        clr      = 4'b0100;
        tick();
        clr      = '0;
        set_x(2, 500);
        in_valid = 4'b0100;
        tick(2);
        in_valid = '0;
        tick(3);

        // clear coinciding with a back-to-back accept on the same channel
        set_x(2, 8191);
        in_valid = 4'b0100;
        tick(1500);
        clr = 4'b0100;
        tick();
        clr = '0;
        tick(20);
        in_valid = '0;
        tick(3);

        // async reset while busy; pointer must restart at channel 0
        set_x(0, 1234);
        set_x(2, 777);
        set_x(3, -555);
        in_valid = 4'b1100;
        tick(9);
        check("busy_mid", longint'(busy), 1);
        #2;
        rstn     = 1'b0;
        in_valid = '0;
        #1;
        check("arst_out_valid", longint'(out_valid), 0);
        check("arst_out_data", longint'(out_data != 0), 0);
        check("arst_busy", longint'(busy), 0);
        tick(2);
        rstn = 1'b1;
        tick(5);
        check("post_rst_busy", longint'(busy), 0);
        in_valid = 4'b1001;
        tick();
        in_valid = '0;
        tick(4);

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
